gshare_branch_predictor: RTL and testbench

GSHARE_BRANCH_PREDICTOR -- requirements
Module: gshare_branch_predictor

---
 rtl/gshare_branch_predictor.sv | 57 +++++
 tb/tb_gshare_branch_predictor.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor: saturating-counter branch predictor, bimodal or gshare indexed, with write-through bypass
module gshare_branch_predictor #(
  parameter int INDEX_BITS = 5,
  parameter int CTR_BITS   = 2,
  parameter int GHR_BITS   = 0,
  parameter int INIT_STATE = 1,
  localparam int GW        = (GHR_BITS > 0) ? GHR_BITS : 1
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  en,
  input  logic [INDEX_BITS-1:0] read_addr,
  input  logic                  update_valid,
  input  logic [INDEX_BITS-1:0] update_index,
  input  logic                  was_taken,
  output logic                  prediction,
  output logic [INDEX_BITS-1:0] pred_index,
  output logic [GW-1:0]         ghr
);
  localparam int DEPTH = 1 << INDEX_BITS;
  logic [CTR_BITS-1:0]   r_ctr [DEPTH];
  logic [GW-1:0]         r_ghr;
  logic                  r_pred;
  logic [INDEX_BITS-1:0] r_pidx;
  logic [INDEX_BITS-1:0] w_idx;
  logic [CTR_BITS-1:0]   w_cur;
  logic [CTR_BITS-1:0]   w_next;
  logic [CTR_BITS-1:0]   w_rd;
  // lookup index and the saturated next value of the entry being trained; a same-index lookup sees the new value
  always_comb begin
    w_idx  = (GHR_BITS == 0) ? read_addr : read_addr ^ INDEX_BITS'(r_ghr);
    w_cur  = r_ctr[update_index];
    w_next = was_taken ? ((&w_cur) ? w_cur : w_cur + 1'b1) : ((w_cur == '0) ? w_cur : w_cur - 1'b1);
    w_rd   = (update_valid && update_index == w_idx) ? w_next : r_ctr[w_idx];
  end
  // table training, history shift and registered prediction; reset discards any concurrent lookup or update
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++) r_ctr[i] <= CTR_BITS'(INIT_STATE);
      r_ghr  <= '0;
      r_pred <= 1'b0;
      r_pidx <= '0;
    end else begin
      if (update_valid) begin
        r_ctr[update_index] <= w_next;
        if (GHR_BITS > 0) r_ghr <= GW'({r_ghr, was_taken});
      end
      if (en) begin
        r_pred <= w_rd[CTR_BITS-1];
        r_pidx <= w_idx;
      end
    end
  end
  assign prediction = r_pred;
  assign pred_index = r_pidx;
  assign ghr        = r_ghr;
endmodule

// File: tb/tb_gshare_branch_predictor.sv
// tb_gshare_branch_predictor: directed checks of a bimodal instance and a 3-bit-history gshare instance
module tb_gshare_branch_predictor;
  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       en = 1'b0, uv = 1'b0, wt = 1'b0;
  logic [4:0] ra = '0, ui = '0;
  logic       pred;
  logic [4:0] pidx;
  logic [0:0] ghr_b;
  logic       g_en = 1'b0, g_uv = 1'b0, g_wt = 1'b0;
  logic [4:0] g_ra = '0, g_ui = '0;
  logic       g_pred;
  logic [4:0] g_pidx;
  logic [2:0] g_ghr;
  int         n_tests = 0, n_fail = 0;

  gshare_branch_predictor dut (
    .clk(clk), .arst_n(arst_n), .en(en), .read_addr(ra), .update_valid(uv),
    .update_index(ui), .was_taken(wt), .prediction(pred), .pred_index(pidx), .ghr(ghr_b)
  );

  gshare_branch_predictor #(.GHR_BITS(3)) dut_g (
    .clk(clk), .arst_n(arst_n), .en(g_en), .read_addr(g_ra), .update_valid(g_uv),
    .update_index(g_ui), .was_taken(g_wt), .prediction(g_pred), .pred_index(g_pidx), .ghr(g_ghr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic upd(input logic [4:0] idx, input logic t, input int n);
    en = 1'b0; uv = 1'b1; ui = idx; wt = t;
    repeat (n) step();
    uv = 1'b0;
  endtask

  task automatic look(input logic [4:0] a);
    en = 1'b1; ra = a; uv = 1'b0;
    step();
    en = 1'b0;
  endtask

  initial begin
    step(); step();
    chk("rst_pred", 32'(pred), 0);
    chk("rst_pidx", 32'(pidx), 0);
    chk("rst_ghr_g", 32'(g_ghr), 0);
    arst_n = 1'b1;
    en = 1'b1;
    for (int a = 0; a < 32; a++) begin
      ra = 5'(a);
      step();
      chk("scan_pred", 32'(pred), 0);
      chk("scan_pidx", 32'(pidx), 32'(a));
    end
    en = 1'b0;
    upd(5'd8, 1'b1, 1);
    look(5'd8);  chk("idx8_trained", 32'(pred), 1);
    upd(5'd7, 1'b1, 1);
    look(5'd7);  chk("inc_once", 32'(pred), 1);
    upd(5'd7, 1'b1, 3);
    look(5'd7);  chk("sat_high", 32'(pred), 1);
    upd(5'd7, 1'b0, 1);
    look(5'd7);  chk("dec_from_3", 32'(pred), 1);
    upd(5'd7, 1'b0, 1);
    look(5'd7);  chk("dec_to_1", 32'(pred), 0);
    upd(5'd7, 1'b0, 3);
    look(5'd7);  chk("sat_low", 32'(pred), 0);
    upd(5'd7, 1'b0, 1);
    upd(5'd7, 1'b1, 1);
    look(5'd7);  chk("no_wrap_low", 32'(pred), 0);
    upd(5'd7, 1'b1, 1);
    look(5'd7);  chk("climb_to_2", 32'(pred), 1);
    look(5'd8);  chk("idx8_untouched", 32'(pred), 1);
    look(5'd6);  chk("idx6_untouched", 32'(pred), 0);
    en = 1'b1; ra = 5'd4; uv = 1'b1; ui = 5'd4; wt = 1'b1;
    step();
    chk("bypass_inc", 32'(pred), 1);
    chk("bypass_pidx", 32'(pidx), 4);
    uv = 1'b0; en = 1'b0;
    look(5'd3);  chk("bypass_nb3", 32'(pred), 0);
    look(5'd5);  chk("bypass_nb5", 32'(pred), 0);
    look(5'd4);  chk("bypass_stored", 32'(pred), 1);
    en = 1'b1; ra = 5'd4; uv = 1'b1; ui = 5'd4; wt = 1'b0;
    step();
    chk("bypass_dec", 32'(pred), 0);
    en = 1'b1; ra = 5'd9; uv = 1'b1; ui = 5'd10; wt = 1'b1;
    step();
    chk("split_lookup", 32'(pred), 0);
    chk("split_pidx", 32'(pidx), 9);
    look(5'd10); chk("split_update", 32'(pred), 1);
    chk("hold_ref_pidx", 32'(pidx), 10);
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      ra = (c % 2 == 0) ? 5'd0 : 5'd31;
      step();
      chk("hold_pred", 32'(pred), 1);
      chk("hold_pidx", 32'(pidx), 10);
    end
    chk("bimodal_ghr", 32'(ghr_b), 0);
    upd(5'd2, 1'b1, 2);
    look(5'd2);  chk("pre_rst_idx2", 32'(pred), 1);
    arst_n = 1'b0; en = 1'b1; ra = 5'd2; uv = 1'b1; ui = 5'd2; wt = 1'b1;
    step();
    chk("midrst_pred", 32'(pred), 0);
    chk("midrst_pidx", 32'(pidx), 0);
    arst_n = 1'b1; uv = 1'b0;
    step();
    chk("post_rst_idx2", 32'(pred), 0);
    chk("post_rst_pidx", 32'(pidx), 2);
    upd(5'd2, 1'b1, 1);
    look(5'd2);  chk("post_rst_init1", 32'(pred), 1);
    g_uv = 1'b1; g_ui = 5'd0; g_wt = 1'b1;
    step(); chk("ghr_1", 32'(g_ghr), 3'b001);
    g_wt = 1'b0;
    step(); chk("ghr_10", 32'(g_ghr), 3'b010);
    g_wt = 1'b1;
    step(); chk("ghr_101", 32'(g_ghr), 3'b101);
    g_uv = 1'b0; g_en = 1'b1; g_ra = 5'b00110;
    step();
    chk("gs_pidx", 32'(g_pidx), 5'b00011);
    chk("gs_pred", 32'(g_pred), 0);
    chk("ghr_hold", 32'(g_ghr), 3'b101);
    g_uv = 1'b1; g_wt = 1'b0;
    step();
    chk("gs_preshift_pidx", 32'(g_pidx), 5'b00011);
    chk("ghr_shift", 32'(g_ghr), 3'b010);
    g_uv = 1'b0;
    step();
    chk("gs_newhist_pidx", 32'(g_pidx), 5'b00100);
    g_en = 1'b0; arst_n = 1'b0;
    step();
    chk("gs_rst_ghr", 32'(g_ghr), 0);
    chk("gs_rst_pidx", 32'(g_pidx), 0);
    arst_n = 1'b1;
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
